// File: rtl/gcn_coo_aggregator.sv
`timescale 1ns/1ps
// GCN combination stage: accumulates ADJ x (FM x WM) by streaming COO edges,
// with optional self-loops, saturating or wrapping accumulate, and sticky error flags.
module gcn_coo_aggregator #(
    parameter int NUM_OF_NODES  = 6,
    parameter int MAX_EDGES     = 6,
    parameter int DOT_PROD_COLS = 3,
    parameter int IN_WIDTH      = 16,
    parameter int ACC_WIDTH     = 16,
    parameter int SELF_LOOP     = 0,
    parameter int SATURATE      = 1,
    parameter int COO_BW        = $clog2(MAX_EDGES),
    parameter int NODE_BW       = $clog2(NUM_OF_NODES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [COO_BW:0]      num_edges,
    output logic [COO_BW-1:0]    coo_address,
    input  logic [NODE_BW-1:0]   coo_in [0:1],
    output logic [NODE_BW-1:0]   read_FM_WM_row,
    input  logic [IN_WIDTH-1:0]  FM_WM_Row [0:DOT_PROD_COLS-1],
    input  logic [NODE_BW-1:0]   read_row_ADJ_FM_WM,
    output logic [ACC_WIDTH-1:0] ADJ_FM_WM_Row [0:DOT_PROD_COLS-1],
    output logic                 busy,
    output logic                 done_comb,
    output logic                 overflow,
    output logic                 bad_index
);

    localparam int E_W   = COO_BW + 1;
    localparam int SUM_W = ACC_WIDTH + 1;
    localparam logic [E_W-1:0]     MAX_E     = E_W'(MAX_EDGES);
    localparam logic [NODE_BW:0]   N_LIM     = (NODE_BW + 1)'(NUM_OF_NODES);
    localparam logic [NODE_BW-1:0] LAST_NODE = NODE_BW'(NUM_OF_NODES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOOP, S_EDGE_A, S_EDGE_B, S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [E_W-1:0]       edge_q, edge_nxt, num_q;
    logic [NODE_BW-1:0]   node_q;
    logic [ACC_WIDTH-1:0] acc_q [NUM_OF_NODES][DOT_PROD_COLS];

    logic                 load, clear, acc_en, edge_adv, node_inc, set_bad, carry;
    logic [NODE_BW-1:0]   acc_row, src, dst;
    logic                 src_ok, dst_ok, rd_ok;
    state_t               adv_state;
    logic [SUM_W-1:0]     sum     [DOT_PROD_COLS];
    logic [ACC_WIDTH-1:0] new_val [DOT_PROD_COLS];

    assign src       = coo_in[0];
    assign dst       = coo_in[1];
    assign src_ok    = {1'b0, src} < N_LIM;
    assign dst_ok    = {1'b0, dst} < N_LIM;
    assign edge_nxt  = edge_q + E_W'(1);
    assign adv_state = (edge_nxt == num_q) ? S_DONE : S_EDGE_A;
    assign busy      = (state_q == S_CLEAR) || (state_q == S_LOOP) ||
                       (state_q == S_EDGE_A) || (state_q == S_EDGE_B);
    assign done_comb = (state_q == S_DONE);

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d        = state_q;
        coo_address    = '0;
        read_FM_WM_row = '0;
        load           = 1'b0;
        clear          = 1'b0;
        acc_en         = 1'b0;
        acc_row        = '0;
        edge_adv       = 1'b0;
        node_inc       = 1'b0;
        set_bad        = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    load    = 1'b1;
                end
            end
            S_CLEAR: begin
                clear = 1'b1;
                if (num_q == '0)         state_d = (SELF_LOOP != 0) ? S_LOOP : S_DONE;
                else if (SELF_LOOP != 0) state_d = S_LOOP;
                else                     state_d = S_EDGE_A;
            end
            S_LOOP: begin
                read_FM_WM_row = node_q;
                acc_en         = 1'b1;
                acc_row        = node_q;
                node_inc       = 1'b1;
                if (node_q == LAST_NODE) state_d = (num_q == '0) ? S_DONE : S_EDGE_A;
            end
            S_EDGE_A: begin
                coo_address    = edge_q[COO_BW-1:0];
                read_FM_WM_row = src;
                if (!(src_ok && dst_ok)) begin
                    set_bad  = 1'b1;
                    edge_adv = 1'b1;
                    state_d  = adv_state;
                end else begin
                    acc_en  = 1'b1;
                    acc_row = dst;
                    if (src == dst) begin
                        edge_adv = 1'b1;
                        state_d  = adv_state;
                    end else begin
                        state_d = S_EDGE_B;
                    end
                end
            end
            S_EDGE_B: begin
                coo_address    = edge_q[COO_BW-1:0];
                read_FM_WM_row = dst;
                acc_en         = 1'b1;
                acc_row        = src;
                edge_adv       = 1'b1;
                state_d        = adv_state;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Zero-extend into one spare bit; the carry decides clamp or wrap.
    always_comb begin
        carry = 1'b0;
        for (int c = 0; c < DOT_PROD_COLS; c++) begin
            sum[c]     = {1'b0, acc_q[acc_row][c]} + SUM_W'(FM_WM_Row[c]);
            carry      = carry | sum[c][ACC_WIDTH];
            new_val[c] = (sum[c][ACC_WIDTH] && (SATURATE != 0)) ? '1 : sum[c][ACC_WIDTH-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the accumulator
    // array is reset as well, since readback must show zeros right after a reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            edge_q    <= '0;
            num_q     <= '0;
            node_q    <= '0;
            overflow  <= 1'b0;
            bad_index <= 1'b0;
            for (int r = 0; r < NUM_OF_NODES; r++)
                for (int c = 0; c < DOT_PROD_COLS; c++)
                    acc_q[r][c] <= '0;
        end else begin
            state_q <= state_d;
            if (load) num_q <= (num_edges > MAX_E) ? MAX_E : num_edges;
            if (clear) begin
                edge_q    <= '0;
                node_q    <= '0;
                overflow  <= 1'b0;
                bad_index <= 1'b0;
                for (int r = 0; r < NUM_OF_NODES; r++)
                    for (int c = 0; c < DOT_PROD_COLS; c++)
                        acc_q[r][c] <= '0;
            end
            if (node_inc) node_q <= node_q + NODE_BW'(1);
            if (edge_adv) edge_q <= edge_nxt;
            if (acc_en) begin
                for (int c = 0; c < DOT_PROD_COLS; c++)
                    acc_q[acc_row][c] <= new_val[c];
                if (carry) overflow <= 1'b1;
            end
            if (set_bad) bad_index <= 1'b1;
        end
    end

    assign rd_ok = {1'b0, read_row_ADJ_FM_WM} < N_LIM;

    always_comb begin
        for (int c = 0; c < DOT_PROD_COLS; c++)
            ADJ_FM_WM_Row[c] = rd_ok ? acc_q[read_row_ADJ_FM_WM][c] : '0;
    end

endmodule

// File: tb/tb_gcn_coo_aggregator.sv
`timescale 1ns/1ps
// Scoreboard bench: two aggregator instances (plain/saturating and self-loop/wrapping)
// share stimulus; a per-instance monitor checks each completed run against a model.
module tb_gcn_coo_aggregator;

    localparam int N    = 6;
    localparam int C    = 3;
    localparam int MAXE = 6;

    typedef struct packed {
        logic [N-1:0][C-1:0][15:0] adj;
        logic                      ovf;
        logic                      bad;
        logic [31:0]               t_done;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       reset, start;
    logic [3:0] num_edges;

    logic [15:0] fm [0:N-1][0:C-1];
    logic [2:0]  csrc [0:MAXE-1];
    logic [2:0]  cdst [0:MAXE-1];

    logic [2:0]  d0_addr, d0_rd, d0_sel, d1_addr, d1_rd, d1_sel;
    logic [2:0]  d0_coo [0:1];
    logic [2:0]  d1_coo [0:1];
    logic [15:0] d0_fm [0:C-1];
    logic [15:0] d1_fm [0:C-1];
    logic [15:0] d0_adj [0:C-1];
    logic [15:0] d1_adj [0:C-1];
    logic        d0_busy, d0_done, d0_ovf, d0_bad;
    logic        d1_busy, d1_done, d1_ovf, d1_bad;

    always_comb begin
        d0_coo[0] = (32'(d0_addr) < MAXE) ? csrc[d0_addr] : 3'd0;
        d0_coo[1] = (32'(d0_addr) < MAXE) ? cdst[d0_addr] : 3'd0;
        d1_coo[0] = (32'(d1_addr) < MAXE) ? csrc[d1_addr] : 3'd0;
        d1_coo[1] = (32'(d1_addr) < MAXE) ? cdst[d1_addr] : 3'd0;
        for (int c = 0; c < C; c++) begin
            d0_fm[c] = (32'(d0_rd) < N) ? fm[d0_rd][c] : 16'd0;
            d1_fm[c] = (32'(d1_rd) < N) ? fm[d1_rd][c] : 16'd0;
        end
    end

    gcn_coo_aggregator #(.SELF_LOOP(0), .SATURATE(1)) dut0 (
        .clk(clk), .reset(reset), .start(start), .num_edges(num_edges),
        .coo_address(d0_addr), .coo_in(d0_coo), .read_FM_WM_row(d0_rd),
        .FM_WM_Row(d0_fm), .read_row_ADJ_FM_WM(d0_sel), .ADJ_FM_WM_Row(d0_adj),
        .busy(d0_busy), .done_comb(d0_done), .overflow(d0_ovf), .bad_index(d0_bad)
    );

    gcn_coo_aggregator #(.SELF_LOOP(1), .SATURATE(0)) dut1 (
        .clk(clk), .reset(reset), .start(start), .num_edges(num_edges),
        .coo_address(d1_addr), .coo_in(d1_coo), .read_FM_WM_row(d1_rd),
        .FM_WM_Row(d1_fm), .read_row_ADJ_FM_WM(d1_sel), .ADJ_FM_WM_Row(d1_adj),
        .busy(d1_busy), .done_comb(d1_done), .overflow(d1_ovf), .bad_index(d1_bad)
    );

    int   checks   = 0;
    int   failures = 0;
    int   pushed   = 0;
    int   done_cnt [2];
    exp_t q0 [$];
    exp_t q1 [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic finish_sim();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    // Reference model: plain integer arithmetic over the edge list.
    int m_acc [N][C];
    bit m_ovf;

    function automatic void m_add(input int r, input int s, input int sat);
        for (int c = 0; c < C; c++) begin
            int v;
            v = m_acc[r][c] + int'(fm[s][c]);
            if (v > 65535) begin
                m_ovf = 1'b1;
                v = (sat != 0) ? 65535 : v - 65536;
            end
            m_acc[r][c] = v;
        end
    endfunction

    function automatic exp_t model(input int sl, input int sat, input int n_in, input int t0);
        exp_t e;
        int   ne, cycles, s, d;
        e = '0;
        m_ovf = 1'b0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < C; c++) m_acc[r][c] = 0;
        ne = (n_in > MAXE) ? MAXE : n_in;
        cycles = 2;
        if (sl != 0) begin
            for (int n = 0; n < N; n++) m_add(n, n, sat);
            cycles += N;
        end
        for (int k = 0; k < ne; k++) begin
            s = int'(csrc[k]);
            d = int'(cdst[k]);
            if (s >= N || d >= N) begin
                e.bad = 1'b1;
                cycles += 1;
            end else if (s == d) begin
                m_add(d, s, sat);
                cycles += 1;
            end else begin
                m_add(d, s, sat);
                m_add(s, d, sat);
                cycles += 2;
            end
        end
        for (int r = 0; r < N; r++)
            for (int c = 0; c < C; c++) e.adj[r][c] = 16'(m_acc[r][c]);
        e.ovf    = m_ovf;
        e.t_done = 32'(t0 + cycles);
        return e;
    endfunction

    function automatic logic get_done(input int id); return (id == 0) ? d0_done : d1_done; endfunction
    function automatic logic get_busy(input int id); return (id == 0) ? d0_busy : d1_busy; endfunction
    function automatic logic get_ovf(input int id);  return (id == 0) ? d0_ovf  : d1_ovf;  endfunction
    function automatic logic get_bad(input int id);  return (id == 0) ? d0_bad  : d1_bad;  endfunction
    function automatic logic [15:0] get_adj(input int id, input int c);
        return (id == 0) ? d0_adj[c] : d1_adj[c];
    endfunction

    task automatic set_sel(input int id, input int r);
        if (id == 0) d0_sel = 3'(r);
        else         d1_sel = 3'(r);
    endtask

    task automatic monitor(input int id);
        logic prev, cur;
        exp_t e;
        prev = 1'b0;
        set_sel(id, 0);
        forever begin
            @(negedge clk);
            #1;
            cur = get_done(id);
            if (cur && !prev) begin
                if (((id == 0) ? q0.size() : q1.size()) == 0) begin
                    check($sformatf("d%0d_spurious_done", id), 0, 1);
                end else begin
                    e = (id == 0) ? q0.pop_front() : q1.pop_front();
                    check($sformatf("d%0d_latency", id), 32'(cyc), e.t_done);
                    check($sformatf("d%0d_overflow", id), 32'(get_ovf(id)), 32'(e.ovf));
                    check($sformatf("d%0d_bad_index", id), 32'(get_bad(id)), 32'(e.bad));
                    check($sformatf("d%0d_busy_in_done", id), 32'(get_busy(id)), 0);
                    for (int r = 0; r < 8; r++) begin
                        set_sel(id, r);
                        #1;
                        for (int c = 0; c < C; c++)
                            check($sformatf("d%0d_adj[%0d][%0d]", id, r, c),
                                  32'(get_adj(id, c)), (r < N) ? 32'(e.adj[r][c]) : 32'd0);
                    end
                    set_sel(id, 0);
                    done_cnt[id]++;
                end
            end
            prev = cur;
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic launch(input int n, input bit expect_result);
        @(negedge clk);
        if (expect_result) begin
            q0.push_back(model(0, 1, n, cyc));
            q1.push_back(model(1, 0, n, cyc));
            pushed++;
        end
        start     = 1'b1;
        num_edges = 4'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 400; i++) begin
            if (done_cnt[0] == pushed && done_cnt[1] == pushed) break;
            @(negedge clk);
        end
        if (i == 400) begin
            check("run_timeout_d0", 32'(done_cnt[0]), 32'(pushed));
            check("run_timeout_d1", 32'(done_cnt[1]), 32'(pushed));
            finish_sim();
        end
    endtask

    task automatic run(input int n);
        launch(n, 1'b1);
        wait_done();
    endtask

    task automatic set_pattern();
        for (int i = 0; i < N; i++)
            for (int c = 0; c < C; c++) fm[i][c] = 16'((i + 1) * (c + 1));
    endtask

    task automatic set_edge(input int k, input int s, input int d);
        csrc[k] = 3'(s);
        cdst[k] = 3'(d);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_d0_busy"}, 32'(d0_busy), 0);
        check({tag, "_d0_done"}, 32'(d0_done), 0);
        check({tag, "_d0_ovf"},  32'(d0_ovf), 0);
        check({tag, "_d0_bad"},  32'(d0_bad), 0);
        check({tag, "_d0_addr"}, 32'(d0_addr), 0);
        check({tag, "_d0_rd"},   32'(d0_rd), 0);
        check({tag, "_d1_busy"}, 32'(d1_busy), 0);
        check({tag, "_d1_rd"},   32'(d1_rd), 0);
        for (int c = 0; c < C; c++) begin
            check($sformatf("%s_d0_adj0_%0d", tag, c), 32'(d0_adj[c]), 0);
            check($sformatf("%s_d1_adj0_%0d", tag, c), 32'(d1_adj[c]), 0);
        end
    endtask

    initial begin
        int t0;
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        reset     = 1'b0;
        start     = 1'b0;
        num_edges = '0;
        set_pattern();
        for (int k = 0; k < MAXE; k++) set_edge(k, 0, 0);
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        reset = 1'b1;

        // Three normal edges, then a self-edge, an empty run, and bad indices.
        set_edge(0, 0, 1); set_edge(1, 1, 2); set_edge(2, 3, 4);
        run(3);
        set_edge(0, 2, 2);
        run(1);
        run(0);
        set_edge(0, 0, 7); set_edge(1, 6, 1); set_edge(2, 4, 5);
        run(3);

        // Large values on the same edge twice push both instances past 16 bits.
        for (int c = 0; c < C; c++) fm[0][c] = 16'hFFFF;
        set_edge(0, 0, 1); set_edge(1, 0, 1);
        run(2);
        set_pattern();

        // num_edges above MAX_EDGES is clamped.
        for (int k = 0; k < MAXE; k++) set_edge(k, k, (k + 2) % N);
        run(15);

        // A start pulse while busy must not disturb the run.
        set_edge(0, 0, 1); set_edge(1, 1, 2); set_edge(2, 3, 4);
        launch(3, 1'b1);
        @(negedge clk);
        start     = 1'b1;
        num_edges = 4'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Reset mid-run, then a clean rerun.
        launch(3, 1'b0);
        t0 = cyc - 1;
        while (cyc < t0 + 4) @(negedge clk);
        reset = 1'b0;
        #1;
        check_idle_outputs("midreset");
        @(negedge clk);
        reset = 1'b1;
        run(3);

        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < N; i++)
                for (int c = 0; c < C; c++)
                    fm[i][c] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(50000, 65535))
                                                           : 16'($urandom_range(0, 200));
            for (int k = 0; k < MAXE; k++)
                set_edge(k,
                         ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5)),
                         ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5)));
            run(int'($urandom_range(0, 15)));
        end

        repeat (2) @(negedge clk);
        check("queue_d0_empty", 32'(q0.size()), 0);
        check("queue_d1_empty", 32'(q1.size()), 0);
        finish_sim();
    end

endmodule
